dm_cmd_arbiter: RTL and testbench
=================================

Name: dm_cmd_arbiter

Overview:
Round-robin arbiter that shares the single data-mover command port (the 64-bit DataMoverCommand stream into the source or destination mover FIFO) between N_REQ command requesters, e.g. several software queues or hardware sequencers. Multi-command chains are kept contiguous: once a requester issues a command with last=0, it holds the port until it issues a command with last=1. A timeout releases abandoned locks. Per-requester issue counters and sticky error flags are provided for the MMIO status path.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_WIDTH, 3, width of requester index (>= clog2(N_REQ))
CMD_WIDTH, 64, command width; bit 55 = last, bits 2:0 = dest
LOCK_TIMEOUT, 256, idle cycles of the lock owner before forced release; 0 disables the timeout
CNT_WIDTH, 16, width of each issue counter

Ports:
aclk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  N_REQ  per-requester command valid
req_cmd  in  N_REQ*CMD_WIDTH  packed commands; requester i occupies bits [i*CMD_WIDTH +: CMD_WIDTH]
req_ready  out  N_REQ  per-requester accept
out_valid  out  1  registered command valid toward the mover FIFO
out_cmd  out  CMD_WIDTH  registered command
out_id  out  ID_WIDTH  index of the requester that issued out_cmd
out_ready  in  1  downstream accept
locked  out  1  a chain is in progress
lock_owner  out  ID_WIDTH  owner while locked, else 0
issue_cnt  out  N_REQ*CNT_WIDTH  commands accepted per requester; wraps
err_timeout  out  N_REQ  sticky: the lock of this requester was force-released
err_clr  in  N_REQ  clear the corresponding err_timeout bits

Behaviour:
- Reset values: out_valid=0, out_cmd=0, out_id=0, locked=0, lock_owner=0, issue_cnt=0, err_timeout=0, rr pointer=0, timeout counter=0. req_ready is forced to 0 while rst=1.
- Output stage: a single register. space = !out_valid || out_ready. A transfer on input i occurs when req_valid[i] && req_ready[i]. Transfer at cycle t gives out_valid=1 with that cmd/id at t+1. out_valid drops when out_ready=1 and there is no new transfer. Full throughput is one command per cycle.
- State IDLE (locked=0):
  - Grant = first i with req_valid[i], searching ptr, ptr+1, ... modulo N_REQ.
  - req_ready[grant] = space. All other req_ready bits are 0.
  - req_ready depends combinationally on req_valid within the same cycle.
  - On transfer with cmd[55]=1: ptr <= grant+1 mod N_REQ; stay in IDLE.
  - On transfer with cmd[55]=0: go to LOCKED; lock_owner <= grant; timeout counter cleared.
- State LOCKED:
  - req_ready[owner] = space. All other req_ready bits are 0.
  - On owner transfer with last=1: go to IDLE; ptr <= owner+1; lock_owner <= 0.
  - On owner transfer with last=0: stay in LOCKED; counter cleared.
- Timeout (LOCK_TIMEOUT>0):
  - In LOCKED, the counter increments each cycle in which req_valid[owner]=0. It clears on any owner transfer.
  - A cycle with req_valid[owner]=1 but space=0 neither increments nor clears the counter (downstream backpressure is not a timeout).
  - When the counter reaches LOCK_TIMEOUT: go to IDLE the next cycle; ptr <= owner+1; err_timeout[owner] <= 1. No command is synthesized.
  - If an owner transfer and the timeout occur in the same cycle, the transfer wins and the counter clears.
- issue_cnt[i] increments by 1 on each transfer from requester i and wraps from all-ones to 0.
- err_timeout: if set and err_clr fire in the same cycle, set wins.
- Commands pass through unmodified; dest range checking belongs to the mover side.
- A reset asserted mid-chain drops the lock and any registered command. Requesters must re-issue.

Test Plan:
1. Reset, then N_REQ=4 with all req_valid=1, each command with last=1, out_ready=1 -> out_id sequence 0,1,2,3,0,...; out_valid stays high; each issue_cnt increments by 1 per 4 cycles.
2. Requester 1 issues 3 commands with last=0,0,1 while requesters 0 and 2 are valid -> out_id = 1,1,1 back-to-back; locked=1 for the first two; next grant goes to 2.
3. out_ready held 0 for 5 cycles with out_valid=1 -> all req_ready=0 and out_cmd stable; on release, the next command appears one cycle later with no loss or duplication.
4. LOCK_TIMEOUT=8: requester 3 issues a command with last=0, then drops valid -> after 8 cycles locked=0 and err_timeout[3]=1; requester 0 is granted next; err_clr[3]=1 clears the bit.
5. Requester 2 locked with valid=1 and out_ready=0 for 20 cycles (LOCK_TIMEOUT=8) -> no timeout; err_timeout=0.
6. rst pulsed while locked with out_valid=1 -> next cycle out_valid=0, locked=0, issue_cnt=0, and round-robin restarts at requester 0.

Source files
------------

// File: rtl/dm_cmd_arbiter.sv
// Round-robin arbiter sharing one data-mover command port between N_REQ requesters.
// Multi-command chains (last=0 ... last=1) hold the port; an idle lock owner is released by timeout.
module dm_cmd_arbiter #(
    parameter int N_REQ        = 4,
    parameter int ID_WIDTH     = 3,
    parameter int CMD_WIDTH    = 64,
    parameter int LOCK_TIMEOUT = 256,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                       aclk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*CMD_WIDTH-1:0] req_cmd,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       out_valid,
    output logic [CMD_WIDTH-1:0]       out_cmd,
    output logic [ID_WIDTH-1:0]        out_id,
    input  logic                       out_ready,
    output logic                       locked,
    output logic [ID_WIDTH-1:0]        lock_owner,
    output logic [N_REQ*CNT_WIDTH-1:0] issue_cnt,
    output logic [N_REQ-1:0]           err_timeout,
    input  logic [N_REQ-1:0]           err_clr
);

    localparam int LAST_BIT = 55;
    localparam int TMO_W    = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t                 state_q, state_d;
    logic [ID_WIDTH-1:0]    ptr_q, ptr_d;
    logic [ID_WIDTH-1:0]    owner_q, owner_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   ov_q, ov_d;
    logic [CMD_WIDTH-1:0]   ocmd_q, ocmd_d;
    logic [ID_WIDTH-1:0]    oid_q, oid_d;
    logic [N_REQ-1:0]       err_q, err_d;
    logic [CNT_WIDTH-1:0]   icnt_q [N_REQ];
    logic [CNT_WIDTH-1:0]   icnt_d [N_REQ];

    logic                   space;
    logic                   gnt_found;
    logic [ID_WIDTH-1:0]    gnt_idx;
    logic [ID_WIDTH-1:0]    sel_idx;
    logic [CMD_WIDTH-1:0]   sel_cmd;
    logic                   sel_vld;
    logic                   sel_last;
    logic [N_REQ-1:0]       ack;
    logic                   xfer;
    logic                   expire;
    logic [N_REQ-1:0]       err_set;

    function automatic logic [ID_WIDTH-1:0] next_idx(input logic [ID_WIDTH-1:0] i);
        if (int'(i) >= N_REQ - 1) begin
            return '0;
        end else begin
            return i + ID_WIDTH'(1);
        end
    endfunction

    assign space = !ov_q || out_ready;

    // Rotating priority: first valid at or above ptr, otherwise first valid below it.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_found && i >= int'(ptr_q) && req_valid[i]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_WIDTH'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_found && req_valid[i]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_WIDTH'(i);
            end
        end
    end

    always_comb begin
        sel_idx   = (state_q == S_LOCKED) ? owner_q : gnt_idx;
        sel_cmd   = '0;
        sel_vld   = 1'b0;
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (i == int'(sel_idx)) begin
                sel_cmd      = req_cmd[i*CMD_WIDTH +: CMD_WIDTH];
                sel_vld      = req_valid[i];
                req_ready[i] = !rst && space && ((state_q == S_LOCKED) || gnt_found);
            end
        end
        sel_last = sel_cmd[LAST_BIT];
        ack      = req_valid & req_ready;
        xfer     = |ack;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        tmo_d   = tmo_q;
        expire  = 1'b0;
        err_set = '0;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    if (sel_last) begin
                        ptr_d = next_idx(sel_idx);
                    end else begin
                        state_d = S_LOCKED;
                        owner_d = sel_idx;
                        tmo_d   = '0;
                    end
                end
            end
            S_LOCKED: begin
                if (xfer) begin
                    tmo_d = '0;
                    if (sel_last) begin
                        state_d = S_IDLE;
                        ptr_d   = next_idx(owner_q);
                        owner_d = '0;
                    end
                end else if (LOCK_TIMEOUT > 0 && tmo_q == TMO_W'(LOCK_TIMEOUT)) begin
                    expire  = 1'b1;
                    state_d = S_IDLE;
                    ptr_d   = next_idx(owner_q);
                    owner_d = '0;
                    tmo_d   = '0;
                end else if (LOCK_TIMEOUT > 0 && !sel_vld) begin
                    // Owner stalled by backpressure (valid but no space) does not age the lock.
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        for (int i = 0; i < N_REQ; i++) begin
            if (expire && i == int'(owner_q)) begin
                err_set[i] = 1'b1;
            end
        end
        err_d = (err_q & ~err_clr) | err_set;
    end

    always_comb begin
        ov_d   = ov_q;
        ocmd_d = ocmd_q;
        oid_d  = oid_q;
        if (xfer) begin
            ov_d   = 1'b1;
            ocmd_d = sel_cmd;
            oid_d  = sel_idx;
        end else if (out_ready) begin
            ov_d = 1'b0;
        end
        for (int i = 0; i < N_REQ; i++) begin
            icnt_d[i] = icnt_q[i] + CNT_WIDTH'(ack[i]);
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            tmo_q   <= '0;
            ov_q    <= 1'b0;
            ocmd_q  <= '0;
            oid_q   <= '0;
            err_q   <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                icnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            tmo_q   <= tmo_d;
            ov_q    <= ov_d;
            ocmd_q  <= ocmd_d;
            oid_q   <= oid_d;
            err_q   <= err_d;
            for (int i = 0; i < N_REQ; i++) begin
                icnt_q[i] <= icnt_d[i];
            end
        end
    end

    assign out_valid   = ov_q;
    assign out_cmd     = ocmd_q;
    assign out_id      = oid_q;
    assign locked      = (state_q == S_LOCKED);
    assign lock_owner  = owner_q;
    assign err_timeout = err_q;

    for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
        assign issue_cnt[g*CNT_WIDTH +: CNT_WIDTH] = icnt_q[g];
    end

endmodule

// File: tb/tb_dm_cmd_arbiter.sv
// Directed bench for dm_cmd_arbiter: round-robin, chains, backpressure, timeout, reset.
module tb_dm_cmd_arbiter;

    localparam int N  = 4;
    localparam int IW = 3;
    localparam int CW = 64;
    localparam int KW = 16;

    logic            aclk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*CW-1:0] req_cmd;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [CW-1:0]   out_cmd;
    logic [IW-1:0]   out_id;
    logic            out_ready;
    logic            locked;
    logic [IW-1:0]   lock_owner;
    logic [N*KW-1:0] issue_cnt;
    logic [N-1:0]    err_timeout;
    logic [N-1:0]    err_clr;

    int checks;
    int failures;

    dm_cmd_arbiter #(
        .N_REQ(N), .ID_WIDTH(IW), .CMD_WIDTH(CW), .LOCK_TIMEOUT(8), .CNT_WIDTH(KW)
    ) dut (
        .aclk(aclk), .rst(rst), .req_valid(req_valid), .req_cmd(req_cmd),
        .req_ready(req_ready), .out_valid(out_valid), .out_cmd(out_cmd),
        .out_id(out_id), .out_ready(out_ready), .locked(locked),
        .lock_owner(lock_owner), .issue_cnt(issue_cnt),
        .err_timeout(err_timeout), .err_clr(err_clr)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [63:0] mk(input int id, input int seq, input bit last);
        logic [63:0] c;
        c        = '0;
        c[63:56] = 8'(8'hC0 + id);
        c[55]    = last;
        c[15:0]  = 16'(seq);
        return c;
    endfunction

    task automatic set_cmd(input int i, input logic [63:0] c);
        req_cmd[i*CW +: CW] = c;
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_cmd   = '0;
        out_ready = 1'b0;
        err_clr   = '0;
        tick();
        req_valid = 4'hF;
        for (int i = 0; i < N; i++) set_cmd(i, mk(i, 16'h100 + i, 1'b1));
        #1;
        chk("rst_ready", 64'(req_ready), 64'h0);
        tick();
        chk("rst_ovalid", 64'(out_valid), 64'h0);
        chk("rst_ocmd", out_cmd, 64'h0);
        chk("rst_oid", 64'(out_id), 64'h0);
        chk("rst_locked", 64'(locked), 64'h0);
        chk("rst_owner", 64'(lock_owner), 64'h0);
        chk("rst_icnt", issue_cnt, 64'h0);
        chk("rst_err", 64'(err_timeout), 64'h0);

        // 1: all valid, last=1 -> ids rotate 0,1,2,3,...
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("t1_ready0", 64'(req_ready), 64'h1);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t1_ovalid", 64'(out_valid), 64'h1);
            chk("t1_oid", 64'(out_id), 64'(k % 4));
            chk("t1_ocmd", out_cmd, mk(k % 4, 16'h100 + (k % 4), 1'b1));
            chk("t1_ready", 64'(req_ready), 64'(1 << ((k + 1) % 4)));
        end
        chk("t1_icnt", issue_cnt, {16'd2, 16'd2, 16'd2, 16'd2});

        // 2: move ptr to 1, then requester 1 chain with 0 and 2 valid
        req_valid = 4'b0001;
        set_cmd(0, mk(0, 16'h200, 1'b1));
        tick();
        chk("t2_pre_oid", 64'(out_id), 64'h0);
        req_valid = 4'b0111;
        set_cmd(0, mk(0, 16'h201, 1'b1));
        set_cmd(1, mk(1, 16'h210, 1'b0));
        set_cmd(2, mk(2, 16'h220, 1'b1));
        #1;
        chk("t2_ready_a", 64'(req_ready), 64'h2);
        tick();
        chk("t2_oid_a", 64'(out_id), 64'h1);
        chk("t2_ocmd_a", out_cmd, mk(1, 16'h210, 1'b0));
        chk("t2_locked_a", 64'(locked), 64'h1);
        chk("t2_owner_a", 64'(lock_owner), 64'h1);
        chk("t2_ready_b", 64'(req_ready), 64'h2);
        set_cmd(1, mk(1, 16'h211, 1'b0));
        tick();
        chk("t2_oid_b", 64'(out_id), 64'h1);
        chk("t2_ocmd_b", out_cmd, mk(1, 16'h211, 1'b0));
        chk("t2_locked_b", 64'(locked), 64'h1);
        set_cmd(1, mk(1, 16'h212, 1'b1));
        tick();
        chk("t2_oid_c", 64'(out_id), 64'h1);
        chk("t2_ocmd_c", out_cmd, mk(1, 16'h212, 1'b1));
        chk("t2_locked_c", 64'(locked), 64'h0);
        chk("t2_owner_c", 64'(lock_owner), 64'h0);
        chk("t2_ready_next", 64'(req_ready), 64'h4);
        tick();
        chk("t2_oid_next", 64'(out_id), 64'h2);
        chk("t2_ocmd_next", out_cmd, mk(2, 16'h220, 1'b1));

        // 3: backpressure for 5 cycles
        out_ready = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < N; i++) set_cmd(i, mk(i, 16'h300 + i, 1'b1));
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t3_ready_bp", 64'(req_ready), 64'h0);
            tick();
            chk("t3_ovalid_bp", 64'(out_valid), 64'h1);
            chk("t3_ocmd_bp", out_cmd, mk(2, 16'h220, 1'b1));
        end
        out_ready = 1'b1;
        #1;
        chk("t3_ready_rel", 64'(req_ready), 64'h8);
        tick();
        chk("t3_oid_a", 64'(out_id), 64'h3);
        chk("t3_ocmd_a", out_cmd, mk(3, 16'h303, 1'b1));
        tick();
        chk("t3_oid_b", 64'(out_id), 64'h0);
        chk("t3_ocmd_b", out_cmd, mk(0, 16'h300, 1'b1));
        req_valid = 4'b0000;
        tick();
        chk("t3_ovalid_drain", 64'(out_valid), 64'h0);
        chk("t3_icnt", issue_cnt, {16'd3, 16'd3, 16'd5, 16'd4});

        // 4: requester 3 locks then goes idle -> timeout after 8 idle cycles
        req_valid = 4'b1000;
        set_cmd(3, mk(3, 16'h400, 1'b0));
        tick();
        chk("t4_locked", 64'(locked), 64'h1);
        chk("t4_owner", 64'(lock_owner), 64'h3);
        req_valid = 4'b0001;
        set_cmd(0, mk(0, 16'h410, 1'b1));
        #1;
        chk("t4_ready_lock", 64'(req_ready), 64'h8);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("t4_still_locked", 64'(locked), 64'h1);
        end
        chk("t4_ovalid_idle", 64'(out_valid), 64'h0);
        chk("t4_err_pre", 64'(err_timeout), 64'h0);
        tick();
        chk("t4_released", 64'(locked), 64'h0);
        chk("t4_owner_rel", 64'(lock_owner), 64'h0);
        chk("t4_err_set", 64'(err_timeout), 64'h8);
        chk("t4_ovalid_none", 64'(out_valid), 64'h0);
        chk("t4_ready_next", 64'(req_ready), 64'h1);
        err_clr = 4'b1000;
        tick();
        chk("t4_oid_next", 64'(out_id), 64'h0);
        chk("t4_ocmd_next", out_cmd, mk(0, 16'h410, 1'b1));
        chk("t4_err_clr", 64'(err_timeout), 64'h0);
        err_clr   = '0;
        req_valid = '0;

        // 5: requester 2 locked, valid but backpressured for 20 cycles -> no timeout
        req_valid = 4'b0100;
        set_cmd(2, mk(2, 16'h500, 1'b0));
        tick();
        chk("t5_locked", 64'(locked), 64'h1);
        chk("t5_owner", 64'(lock_owner), 64'h2);
        set_cmd(2, mk(2, 16'h501, 1'b1));
        out_ready = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        chk("t5_locked_hold", 64'(locked), 64'h1);
        chk("t5_err", 64'(err_timeout), 64'h0);
        chk("t5_ocmd_hold", out_cmd, mk(2, 16'h500, 1'b0));
        chk("t5_ready_bp", 64'(req_ready), 64'h0);
        out_ready = 1'b1;
        tick();
        chk("t5_ocmd_end", out_cmd, mk(2, 16'h501, 1'b1));
        chk("t5_unlocked", 64'(locked), 64'h0);

        // 6: reset mid-chain with a registered command
        req_valid = 4'b0001;
        set_cmd(0, mk(0, 16'h600, 1'b0));
        tick();
        chk("t6_locked", 64'(locked), 64'h1);
        chk("t6_ovalid", 64'(out_valid), 64'h1);
        rst = 1'b1;
        #1;
        chk("t6_ready_rst", 64'(req_ready), 64'h0);
        tick();
        chk("t6_ovalid_rst", 64'(out_valid), 64'h0);
        chk("t6_locked_rst", 64'(locked), 64'h0);
        chk("t6_icnt_rst", issue_cnt, 64'h0);
        rst       = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < N; i++) set_cmd(i, mk(i, 16'h700 + i, 1'b1));
        #1;
        chk("t6_ready_restart", 64'(req_ready), 64'h1);
        tick();
        chk("t6_oid_restart", 64'(out_id), 64'h0);
        chk("t6_icnt_restart", issue_cnt, 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
